// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_pkg
// Brief    : Shared types and constants for the multi-channel LED blinker.
// Revision : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

endpackage
`default_nettype wire

// File: rtl/led_blink_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_multi_if
// Brief    : Valid/ready configuration write port for led_blink_multi.
// Revision : 1.0 - initial release
// ============================================================================
interface led_blink_multi_if
    import led_blink_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    led_mode_t        cfg_mode;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_div,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/led_blink_ch.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_ch
// Brief    : One LED channel: prescaler, mode register, breathe duty ramp.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int               CNT_W       = 24,
    parameter int               PWM_W       = 8,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(12_499_999)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  led_mode_t        load_mode,
    input  logic [CNT_W-1:0] load_div,
    input  logic             sync,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic             tick
);

    localparam logic [PWM_W-1:0] c_DUTY_MAX = {PWM_W{1'b1}};

    led_mode_t        r_mode;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_dir_down;
    logic             r_led;
    logic             r_tick;

    logic             w_wrap;
    logic [PWM_W-1:0] w_duty_step;

    always_comb begin
        w_wrap      = (r_cnt == r_div);
        w_duty_step = r_dir_down ? (r_duty - 1'b1) : (r_duty + 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_BLINK;
            r_div      <= DEFAULT_DIV;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
            r_led      <= 1'b0;
            r_tick     <= 1'b0;
        end else if (load || sync) begin
            // A write landing together with a phase sync still takes the new settings
            if (load) begin
                r_mode <= load_mode;
                r_div  <= load_div;
            end
            r_cnt      <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
            r_led      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : (r_cnt + 1'b1);
            r_tick <= w_wrap;
            case (r_mode)
                MODE_OFF:   r_led <= 1'b0;
                MODE_ON:    r_led <= 1'b1;
                MODE_BLINK: if (w_wrap) r_led <= ~r_led;
                default: begin
                    r_led <= (pwm_cnt < r_duty);
                    // Direction reverses on reaching an end, so the ends are held for one step only
                    if (w_wrap) begin
                        r_duty <= w_duty_step;
                        if (w_duty_step == c_DUTY_MAX)
                            r_dir_down <= 1'b1;
                        else if (w_duty_step == '0)
                            r_dir_down <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/led_blink_multi.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_multi
// Brief    : NUM_CH-channel LED driver (OFF/ON/BLINK/BREATHE) with config port.
//            Optional LED_PHASE_SYNC_EN adds sync_in to restart all channels.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 24,
    parameter int               PWM_W       = 8,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(12_499_999)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LED_PHASE_SYNC_EN
    input  logic              sync_in,
`endif
    led_blink_multi_if.slave  cfg,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] tick
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             r_ready;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             w_accept;
    logic             w_sync;

`ifdef LED_PHASE_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_accept      = cfg.cfg_valid & r_ready;
    assign cfg.cfg_ready = r_ready;

    // Ready drops for exactly the cycle after each accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ready <= 1'b1;
        else
            r_ready <= ~w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pwm_cnt <= '0;
        else if (w_sync)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end

    // Out-of-range channel indices decode to no load strobe at all
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_load;
        assign w_load = w_accept && (cfg.cfg_ch == CH_W'(i));

        led_blink_ch #(
            .CNT_W       (CNT_W),
            .PWM_W       (PWM_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load),
            .load_mode (cfg.cfg_mode),
            .load_div  (cfg.cfg_div),
            .sync      (w_sync),
            .pwm_cnt   (r_pwm_cnt),
            .led       (led[i]),
            .tick      (tick[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_multi
// Brief    : Scoreboard bench for led_blink_multi (3 channels, small dividers).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_multi;
    import led_blink_pkg::*;

    localparam int               NUM_CH      = 3;
    localparam int               CNT_W       = 8;
    localparam int               PWM_W       = 2;
    localparam logic [CNT_W-1:0] DEFAULT_DIV = 8'd3;
    localparam int               CH_W        = 2;
    localparam longint           PWM_MOD     = 1 << PWM_W;
    localparam longint           DUTY_MAX    = PWM_MOD - 1;
`ifdef LED_PHASE_SYNC_EN
    localparam bit               HAS_SYNC    = 1'b1;
`else
    localparam bit               HAS_SYNC    = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync_in = 1'b0;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] tick;

    led_blink_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

    led_blink_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .PWM_W       (PWM_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef LED_PHASE_SYNC_EN
        .sync_in (sync_in),
`endif
        .cfg     (cfg_if.slave),
        .led     (led),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] tick;
        logic              ready;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_armed = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: each channel is described by its settings and the number
    // of clock edges since it was last (re)started, not by counter registers.
    int     m_mode[NUM_CH];
    longint m_div[NUM_CH];
    longint m_age[NUM_CH];
    longint m_pwm_age;
    bit     m_ready;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic longint tri_wave(longint n);
        longint r;
        r = n % (2 * DUTY_MAX);
        return (r <= DUTY_MAX) ? r : (2 * DUTY_MAX - r);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = int'(MODE_BLINK);
            m_div[i]  = longint'(DEFAULT_DIV);
            m_age[i]  = 0;
        end
        m_pwm_age = 0;
        m_ready   = 1'b1;
    endfunction

    function automatic exp_t model_step(bit v, int ch, int mode, int div, bit s);
        exp_t   e;
        bit     acc;
        longint na;
        longint period;
        e   = '0;
        acc = v && m_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((acc && ch == i) || s) begin
                if (acc && ch == i) begin
                    m_mode[i] = mode;
                    m_div[i]  = div;
                end
                m_age[i] = 0;
            end else begin
                period    = m_div[i] + 1;
                na        = m_age[i] + 1;
                e.tick[i] = (na % period) == 0;
                case (m_mode[i])
                    0:       e.led[i] = 1'b0;
                    1:       e.led[i] = 1'b1;
                    2:       e.led[i] = ((na / period) % 2) == 1;
                    default: e.led[i] = (m_pwm_age % PWM_MOD) < tri_wave(m_age[i] / period);
                endcase
                m_age[i] = na;
            end
        end
        m_pwm_age = s ? 0 : m_pwm_age + 1;
        m_ready   = !acc;
        e.ready   = m_ready;
        return e;
    endfunction

    // One clock of stimulus, with its expected result queued for the monitor
    task automatic cycle(bit v, int ch, int mode, int div, bit s, bit r);
        exp_t e;
        @(negedge clk);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_mode  = led_mode_t'(mode[1:0]);
        cfg_if.cfg_div   = CNT_W'(div);
        sync_in          = s && HAS_SYNC;
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            check("async_rst_led", 64'(led), 64'(0));
            check("async_rst_tick", 64'(tick), 64'(0));
            check("async_rst_ready", 64'(cfg_if.cfg_ready), 64'(1));
        end
        rst = r;
        if (r) begin
            model_reset();
            e       = '0;
            e.ready = 1'b1;
        end else begin
            e = model_step(v, ch, mode, div, s && HAS_SYNC);
        end
        sb_q.push_back(e);
        sb_armed = 1'b1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("led", 64'(led), 64'(e.led));
                check("tick", 64'(tick), 64'(e.tick));
                check("cfg_ready", 64'(cfg_if.cfg_ready), 64'(e.ready));
            end else if (sb_armed) begin
                check("scoreboard_underflow", 64'(1), 64'(0));
            end
        end
    end

    initial begin : stimulus
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = MODE_OFF;
        cfg_if.cfg_div   = '0;
        model_reset();

        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(12);

        cycle(1, 2, int'(MODE_ON), 3, 0, 0);
        idle(6);
        cycle(1, 1, int'(MODE_BLINK), 0, 0, 0);
        idle(6);
        cycle(1, 0, int'(MODE_BREATHE), 0, 0, 0);
        idle(30);

        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(10);
        cycle(1, 3, int'(MODE_OFF), 0, 0, 0);
        idle(4);

        for (int k = 0; k < 6; k++) cycle(1, k % 3, k % 4, k, 0, 0);
        idle(4);

        cycle(1, 0, int'(MODE_BLINK), 1, 0, 0);
        cycle(1, 1, int'(MODE_BLINK), 2, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 2, int'(MODE_BREATHE), 4, 0, 0);
        idle(9);
        cycle(0, 0, 0, 0, 1, 0);
        idle(12);
        cycle(1, 1, int'(MODE_ON), 2, 1, 0);
        idle(6);

        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 6)),
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 299) == 0);
        end
        idle(2);

        @(negedge clk);
        sb_armed = 1'b0;
        check("scoreboard_drain", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
